branch_history_predictor: RTL and testbench



---
 rtl/branch_history_predictor.sv | 112 +++++++++++
 tb/tb_branch_history_predictor.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/branch_history_predictor.sv
// branch_history_predictor: PC-indexed table of 2-bit saturating counters with mispredict flag and perf counters.
// Define BHP_GSHARE_EN to fold a global history register into the table index (gshare); default is bimodal.
module branch_history_predictor #(
    parameter int IDX_BITS  = 6,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [31:0]          if_pc,
    output logic                 pred_taken,
    output logic [IDX_BITS-1:0]  pred_ghr,
    input  logic                 upd_valid,
    input  logic [31:0]          upd_pc,
    input  logic                 upd_br_en,
    input  logic                 upd_pred_taken,
    input  logic [IDX_BITS-1:0]  upd_ghr,
    output logic                 mispredict,
    output logic [CNT_WIDTH-1:0] br_count,
    output logic [CNT_WIDTH-1:0] mp_count
);
    localparam int         ENTRIES = 1 << IDX_BITS;
    localparam logic [1:0] CTR_WNT = 2'b01;

    function automatic logic [1:0] sat_ctr(input logic [1:0] c, input logic taken);
        if (taken)
            return (c == 2'b11) ? c : c + 2'd1;
        else
            return (c == 2'b00) ? c : c - 2'd1;
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    logic [ENTRIES-1:0][1:0] table_q, table_d;
    logic                    mispredict_q, mispredict_d;
    logic [CNT_WIDTH-1:0]    br_count_q, br_count_d;
    logic [CNT_WIDTH-1:0]    mp_count_q, mp_count_d;
    logic [IDX_BITS-1:0]     rd_idx, wr_idx;
    logic                    upd_mp;

    assign upd_mp = upd_valid & (upd_br_en != upd_pred_taken);

`ifdef BHP_GSHARE_EN
    logic [IDX_BITS-1:0] ghr_q, ghr_d;

    assign rd_idx   = if_pc[IDX_BITS+1:2] ^ ghr_q;
    assign wr_idx   = upd_pc[IDX_BITS+1:2] ^ upd_ghr;
    assign pred_ghr = ghr_q;

    // A mispredict rebuilds history from the snapshot the branch carried, discarding wrong-path shifts.
    always_comb begin
        ghr_d = ghr_q;
        if (upd_mp)
            ghr_d = {upd_ghr[IDX_BITS-2:0], upd_br_en};
        else if (upd_valid)
            ghr_d = {ghr_q[IDX_BITS-2:0], upd_br_en};
    end

    always_ff @(posedge clk) begin
        if (rst)
            ghr_q <= '0;
        else
            ghr_q <= ghr_d;
    end
`else
    logic unused_ghr;

    assign rd_idx     = if_pc[IDX_BITS+1:2];
    assign wr_idx     = upd_pc[IDX_BITS+1:2];
    assign pred_ghr   = '0;
    assign unused_ghr = ^upd_ghr;
`endif

    logic unused_pc;
    assign unused_pc = ^{if_pc[31:IDX_BITS+2], if_pc[1:0], upd_pc[31:IDX_BITS+2], upd_pc[1:0]};

    // Lookup reads the registered table, so a same-cycle update to the same entry is not bypassed.
    assign pred_taken = table_q[rd_idx][1];

    always_comb begin
        table_d      = table_q;
        br_count_d   = br_count_q;
        mp_count_d   = mp_count_q;
        mispredict_d = upd_mp;
        if (upd_valid) begin
            table_d[wr_idx] = sat_ctr(table_q[wr_idx], upd_br_en);
            br_count_d      = sat_inc(br_count_q);
        end
        if (upd_mp)
            mp_count_d = sat_inc(mp_count_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            table_q      <= {ENTRIES{CTR_WNT}};
            mispredict_q <= 1'b0;
            br_count_q   <= '0;
            mp_count_q   <= '0;
        end else begin
            table_q      <= table_d;
            mispredict_q <= mispredict_d;
            br_count_q   <= br_count_d;
            mp_count_q   <= mp_count_d;
        end
    end

    assign mispredict = mispredict_q;
    assign br_count   = br_count_q;
    assign mp_count   = mp_count_q;

endmodule

// File: tb/tb_branch_history_predictor.sv
// Self-checking bench for branch_history_predictor: directed scenarios then random updates against a counter-table model.
// Built with CNT_WIDTH=4 so perf-counter saturation is reached quickly.
module tb_branch_history_predictor;
    localparam int IDX = 6;
    localparam int CW  = 4;
    localparam int CMAX = (1 << CW) - 1;
`ifdef BHP_GSHARE_EN
    localparam bit GS = 1'b1;
`else
    localparam bit GS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst = 1'b0;
    logic [31:0]     if_pc = '0;
    logic            pred_taken;
    logic [IDX-1:0]  pred_ghr;
    logic            upd_valid = 1'b0;
    logic [31:0]     upd_pc = '0;
    logic            upd_br_en = 1'b0;
    logic            upd_pred_taken = 1'b0;
    logic [IDX-1:0]  upd_ghr = '0;
    logic            mispredict;
    logic [CW-1:0]   br_count;
    logic [CW-1:0]   mp_count;

    branch_history_predictor #(.IDX_BITS(IDX), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_ghr(pred_ghr),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_br_en(upd_br_en),
        .upd_pred_taken(upd_pred_taken), .upd_ghr(upd_ghr), .mispredict(mispredict),
        .br_count(br_count), .mp_count(mp_count)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;

    // Reference state: counter values 0..3 per entry, history as an integer.
    int tbl[64];
    int m_ghr = 0;
    int m_br = 0;
    int m_mp = 0;
    int m_misp = 0;
    bit inited = 1'b0;

    function automatic int entry_of(input logic [31:0] pc, input int hist);
        int base;
        base = int'((pc >> 2) % 64);
        return GS ? (base ^ hist) : base;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step(input bit r, input bit v, input logic [31:0] upc, input bit br,
                        input bit pt, input logic [IDX-1:0] ug, input logic [31:0] ipc,
                        input string tag);
        int e;
        @(negedge clk);
        rst = r; upd_valid = v; upd_pc = upc; upd_br_en = br;
        upd_pred_taken = pt; upd_ghr = ug; if_pc = ipc;
        #1;
        if (inited) chk({tag, "_pred_pre"}, 32'(pred_taken), 32'(tbl[entry_of(ipc, m_ghr)] >= 2));
        @(posedge clk);
        if (r) begin
            foreach (tbl[i]) tbl[i] = 1;
            m_ghr = 0; m_br = 0; m_mp = 0; m_misp = 0;
            inited = 1'b1;
        end else begin
            m_misp = (v && (br != pt)) ? 1 : 0;
            if (v) begin
                e = entry_of(upc, int'(ug));
                tbl[e] = br ? ((tbl[e] == 3) ? 3 : tbl[e] + 1) : ((tbl[e] == 0) ? 0 : tbl[e] - 1);
                m_br = (m_br == CMAX) ? CMAX : m_br + 1;
                if (m_misp != 0) m_mp = (m_mp == CMAX) ? CMAX : m_mp + 1;
                if (GS) m_ghr = (m_misp != 0) ? (((int'(ug) * 2) + int'(br)) % 64)
                                              : (((m_ghr * 2) + int'(br)) % 64);
            end
        end
        #1;
        chk({tag, "_pred_post"}, 32'(pred_taken), 32'(tbl[entry_of(ipc, m_ghr)] >= 2));
        chk({tag, "_mispredict"}, 32'(mispredict), 32'(m_misp));
        chk({tag, "_br_count"}, 32'(br_count), 32'(m_br));
        chk({tag, "_mp_count"}, 32'(mp_count), 32'(m_mp));
        chk({tag, "_pred_ghr"}, 32'(pred_ghr), 32'(m_ghr));
    endtask

    initial begin
        logic [31:0] rp, ip;
        // Reset, then look up 0x40 in an idle cycle.
        step(1, 0, 32'h0, 0, 0, '0, 32'h40, "reset");
        step(0, 0, 32'h0, 0, 0, '0, 32'h40, "idle");
        chk("reset_pred_wnt", 32'(pred_taken), 32'd0);
        chk("reset_br_zero", 32'(br_count), 32'd0);

        // Train 0x40 taken twice while predicted not-taken: two mispredict pulses.
        step(0, 1, 32'h40, 1, 0, '0, 32'h40, "train1");
        chk("train1_pred_now_taken", 32'(pred_taken), 32'd1);
        step(0, 1, 32'h40, 1, 0, '0, 32'h40, "train2");
        chk("train2_mp_count", 32'(mp_count), 32'd2);

        // Walk down from ST to saturate at SNT.
        for (int i = 0; i < 4; i++) step(0, 1, 32'h40, 0, 1, '0, 32'h40, "sat_down");
        chk("sat_down_pred", 32'(pred_taken), 32'd0);
        step(0, 0, 32'h0, 0, 0, '0, 32'h40, "misp_clear");

        // Aliased update through 0x140 while fetching 0x40.
        step(0, 1, 32'h140, 1, 0, '0, 32'h40, "alias_a");
        step(0, 1, 32'h140, 1, 1, '0, 32'h40, "alias_b");
        chk("alias_now_taken", 32'(pred_taken), 32'd1);

        // Reset wins over a coincident update.
        step(1, 1, 32'h40, 1, 0, '0, 32'h40, "rst_upd");
        chk("rst_upd_br_zero", 32'(br_count), 32'd0);
        chk("rst_upd_entry_wnt", 32'(pred_taken), 32'd0);

        // Enough updates to pin both perf counters at all-ones.
        for (int i = 0; i < 20; i++) step(0, 1, 32'h80, i[0], ~i[0], '0, 32'h80, "perf_sat");
        chk("perf_br_saturated", 32'(br_count), 32'(CMAX));
        chk("perf_mp_saturated", 32'(mp_count), 32'(CMAX));

`ifdef BHP_GSHARE_EN
        // Build history 000011, then repair it from a mispredicting snapshot.
        step(1, 0, 32'h0, 0, 0, '0, 32'h40, "gs_reset");
        step(0, 1, 32'h0, 1, 1, 6'd0, 32'h40, "gs_h1");
        step(0, 1, 32'h4, 1, 1, 6'd1, 32'h40, "gs_h2");
        chk("gs_ghr_built", 32'(pred_ghr), 32'h3);
        step(0, 1, 32'h8, 0, 1, 6'd1, 32'h40, "gs_repair");
        chk("gs_ghr_repaired", 32'(pred_ghr), 32'h2);
`endif

        // Random traffic over a small PC range so entries collide often.
        for (int i = 0; i < 120; i++) begin
            rp = (32'($urandom_range(0, 15)) << 2) | (32'($urandom_range(0, 3)) << 8);
            ip = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(0, 3));
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0), rp,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 6'($urandom_range(0, 63)), ip, "rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
